counter_datachk: RTL and testbench

Receive-side checker for the 8-bit incrementing test pattern that the counter data generator drives into the loopback path. It samples returned words and locks onto the mod-2^DATA_W incrementing sequence. Once locked, it flags and counts every word that breaks the sequence. It sits at the far end of the loopback link and feeds its status and counters to the test controller and debug LEDs.

---
 rtl/counter_datachk.sv | 134 +++++++++++++
 tb/tb_counter_datachk.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_datachk.sv
// Receive-side checker for the incrementing test pattern: locks onto the
// mod-2^DATA_W sequence, then flags and counts words that break it.
`timescale 1ns/1ps
module counter_datachk #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned ERR_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              clr,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [31:0]       word_count
);

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    localparam logic [DATA_W-1:0] ONE_D      = DATA_W'(1);
    localparam logic [ERR_W-1:0]  ONE_E      = ERR_W'(1);
    localparam logic [3:0]        LOCK_TH    = 4'(LOCK_CNT);
    localparam logic [3:0]        UNLOCK_TH  = 4'(UNLOCK_CNT);

    state_t             r_state;
    logic [DATA_W-1:0]  r_exp;
    logic [3:0]         r_good_run;
    logic [3:0]         r_bad_run;
    logic               r_locked;
    logic               r_err_pulse;
    logic [ERR_W-1:0]   r_err_count;
    logic [31:0]        r_word_count;

    logic               w_match;
    logic [DATA_W-1:0]  w_data_inc;
    logic [DATA_W-1:0]  w_exp_inc;
    logic [3:0]         w_good_inc;
    logic [3:0]         w_bad_inc;
    logic               w_cnt_en;
    logic               w_err_en;

    always_comb begin
        w_match    = (data_in == r_exp);
        w_data_inc = data_in + ONE_D;
        w_exp_inc  = r_exp + ONE_D;
        w_good_inc = r_good_run + 4'd1;
        w_bad_inc  = r_bad_run + 4'd1;
        w_cnt_en   = data_valid && (r_state == LOCKED);
        w_err_en   = w_cnt_en && !w_match;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SEARCH;
            r_exp       <= '0;
            r_good_run  <= '0;
            r_bad_run   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (data_valid) begin
                case (r_state)
                    SEARCH: begin
                        r_exp      <= w_data_inc;
                        r_good_run <= 4'd1;
                        r_state    <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        // Both match and mismatch follow the received word; only the run length differs.
                        r_exp <= w_data_inc;
                        if (w_match) begin
                            r_good_run <= w_good_inc;
                            if (w_good_inc == LOCK_TH) begin
                                r_state   <= LOCKED;
                                r_locked  <= 1'b1;
                                r_bad_run <= '0;
                            end
                        end else begin
                            r_good_run <= 4'd1;
                        end
                    end
                    LOCKED: begin
                        // Expected value free-runs so one corrupted word costs one error.
                        r_exp <= w_exp_inc;
                        if (w_match) begin
                            r_bad_run <= '0;
                        end else begin
                            r_err_pulse <= 1'b1;
                            r_bad_run   <= w_bad_inc;
                            if (w_bad_inc == UNLOCK_TH) begin
                                r_state  <= SEARCH;
                                r_locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= SEARCH;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count  <= '0;
            r_word_count <= '0;
        end else if (clr) begin
            r_err_count  <= '0;
            r_word_count <= '0;
        end else begin
            if (w_cnt_en) begin
                r_word_count <= r_word_count + 32'd1;
            end
            if (w_err_en && (r_err_count != '1)) begin
                r_err_count <= r_err_count + ONE_E;
            end
        end
    end

    assign locked     = r_locked;
    assign err_pulse  = r_err_pulse;
    assign err_count  = r_err_count;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_counter_datachk.sv
// Self-checking bench for counter_datachk: directed scenarios plus randomized
// traffic compared against a word-level reference model.
`timescale 1ns/1ps
module tb_counter_datachk;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned LOCK_CNT   = 4;
    localparam int unsigned UNLOCK_CNT = 3;
    localparam int unsigned ERR_W      = 6;
    localparam int unsigned ERR_MAX    = (1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_valid = 1'b0;
    logic              clr = 1'b0;
    logic              locked;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;
    logic [31:0]       word_count;

    int checks = 0;
    int failures = 0;

    // Reference model state, in terms of the pattern rules rather than the RTL.
    bit          m_locked;
    bit          m_seeded;
    int          m_exp;
    int          m_good;
    int          m_bad;
    bit          m_pulse;
    int          m_ec;
    int unsigned m_wc;

    counter_datachk #(
        .DATA_W    (DATA_W),
        .LOCK_CNT  (LOCK_CNT),
        .UNLOCK_CNT(UNLOCK_CNT),
        .ERR_W     (ERR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .data_valid(data_valid),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic m_reset();
        m_locked = 0; m_seeded = 0; m_exp = 0; m_good = 0; m_bad = 0;
        m_pulse = 0; m_ec = 0; m_wc = 0;
    endtask

    task automatic m_step(input bit v, input int d, input bit c);
        m_pulse = 0;
        if (v) begin
            if (m_locked) begin
                m_wc++;
                if (d != m_exp) begin
                    m_pulse = 1;
                    if (m_ec < ERR_MAX) m_ec++;
                    m_bad++;
                end else begin
                    m_bad = 0;
                end
                m_exp = (m_exp + 1) % 256;
                if (m_bad == UNLOCK_CNT) begin
                    m_locked = 0;
                    m_seeded = 0;
                end
            end else if (m_seeded && d == m_exp) begin
                m_good++;
                m_exp = (d + 1) % 256;
                if (m_good == LOCK_CNT) begin
                    m_locked = 1;
                    m_bad = 0;
                end
            end else begin
                m_seeded = 1;
                m_good = 1;
                m_exp = (d + 1) % 256;
            end
        end
        if (c) begin
            m_ec = 0;
            m_wc = 0;
        end
    endtask

    task automatic cycle(input bit v, input int d, input bit c);
        @(negedge clk);
        data_valid = v;
        data_in = DATA_W'(d);
        clr = c;
        @(posedge clk);
        #1;
        m_step(v, d, c);
        check("locked", 32'(locked), 32'(m_locked));
        check("err_pulse", 32'(err_pulse), 32'(m_pulse));
        check("err_count", 32'(err_count), 32'(m_ec));
        check("word_count", word_count, m_wc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        data_valid = 1'b0;
        clr = 1'b0;
        #1;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_reset();
        #1;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_word_count", word_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lock-in on 0x00..0x09.
        for (int d = 0; d < 10; d++) begin
            cycle(1, d, 0);
            if (d == 2) check("lockin_pre", 32'(locked), 32'd0);
            if (d == 3) check("lockin_rise", 32'(locked), 32'd1);
        end
        check("lockin_wc", word_count, 32'd6);
        check("lockin_ec", 32'(err_count), 32'd0);

        // Wrap-around through 0xFF -> 0x00.
        do_reset();
        for (int d = 16'hFA; d <= 16'hFD; d++) cycle(1, d, 0);
        check("wrap_locked", 32'(locked), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cycle(1, (16'hFE + k) % 256, 0);
            check("wrap_nopulse", 32'(err_pulse), 32'd0);
            check("wrap_stay", 32'(locked), 32'd1);
        end

        // Single corrupted word.
        do_reset();
        for (int d = 16'h0D; d <= 16'h10; d++) cycle(1, d, 0);
        cycle(1, 16'h11, 0);
        cycle(1, 16'h55, 0);
        check("corr_pulse", 32'(err_pulse), 32'd1);
        cycle(1, 16'h13, 0);
        check("corr_pulse_end", 32'(err_pulse), 32'd0);
        cycle(1, 16'h14, 0);
        check("corr_ec", 32'(err_count), 32'd1);
        check("corr_locked", 32'(locked), 32'd1);

        // Lock loss after three mismatches, then relock.
        do_reset();
        for (int d = 0; d < 4; d++) cycle(1, d, 0);
        cycle(1, 16'hAA, 0);
        cycle(1, 16'hAA, 0);
        check("loss_still", 32'(locked), 32'd1);
        cycle(1, 16'hAA, 0);
        check("loss_fall", 32'(locked), 32'd0);
        check("loss_ec", 32'(err_count), 32'd3);
        for (int d = 16'h20; d < 16'h24; d++) cycle(1, d, 0);
        check("relock", 32'(locked), 32'd1);
        check("relock_ec", 32'(err_count), 32'd3);

        // Gapped valid must match the gapless lock-in result.
        do_reset();
        for (int d = 0; d < 10; d++) begin
            repeat ($urandom_range(0, 2)) cycle(0, $urandom_range(0, 255), 0);
            cycle(1, d, 0);
        end
        check("gap_locked", 32'(locked), 32'd1);
        check("gap_wc", word_count, 32'd6);
        check("gap_ec", 32'(err_count), 32'd0);

        // clr on the same edge as a mismatch.
        cycle(1, 16'h0A, 0);
        cycle(1, 16'h77, 1);
        check("clr_ec", 32'(err_count), 32'd0);
        check("clr_wc", word_count, 32'd0);
        check("clr_pulse", 32'(err_pulse), 32'd1);
        check("clr_locked", 32'(locked), 32'd1);

        // Async reset between clock edges while locked.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_pulse", 32'(err_pulse), 32'd0);
        check("arst_ec", 32'(err_count), 32'd0);
        check("arst_wc", word_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 16'h40; d < 16'h44; d++) begin
            cycle(1, d, 0);
            if (d == 16'h42) check("arst_acq", 32'(locked), 32'd0);
        end
        check("arst_relock", 32'(locked), 32'd1);

        // Error counter saturation: two misses then a hit keeps lock.
        do_reset();
        for (int d = 0; d < 4; d++) cycle(1, d, 0);
        for (int k = 0; k < 35; k++) begin
            cycle(1, m_exp ^ 16'h80, 0);
            cycle(1, m_exp ^ 16'h80, 0);
            cycle(1, m_exp, 0);
        end
        check("sat_ec", 32'(err_count), ERR_MAX);
        check("sat_locked", 32'(locked), 32'd1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            bit v;
            bit c;
            int d;
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 63) == 0);
            d = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 255)) : m_exp;
            cycle(v, d, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
